fb_flip_ctrl: RTL

Frame-buffer page-flip controller between the renderer and the VGA unit's `frame_buffer_ptr` input, which is currently tied to 0. It owns a small pool of SDRAM frame buffers. It hands the renderer a back buffer, queues a flip when the renderer reports a finished frame, and retargets the display at the start of vertical blanking so no frame ever tears.

---
 rtl/fb_flip_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_flip_ctrl.sv
// -----------------------------------------------------------------------------
// fb_flip_ctrl
//
// Frame-buffer page-flip controller. It sits between the renderer and the VGA
// unit's frame_buffer_ptr input and owns a small pool of SDRAM frame buffers.
// The renderer is handed a back buffer. A finished frame is queued as a
// pending flip. The display is retargeted only at the start of vertical
// blanking (falling edge of vga_vs), so a displayed frame never tears.
//
// Build option:
//   FB_FLIP_TRIPLE_BUFFER_EN  defined   -> three buffers with mailbox
//                                          semantics; drop_count is active.
//                             undefined -> two buffers; the renderer stalls
//                                          until vblank; drop_count stays 0.
//
// Parameters:
//   FB_BASE  byte address of buffer 0
//   FB_SIZE  byte size of one buffer (buffer i = FB_BASE + i*FB_SIZE, mod 2^32)
//
// Ports:
//   clk               in   single clock for all logic
//   reset             in   synchronous, active-high
//   vga_vs            in   VGA vertical sync, active-low, asynchronous to clk
//   render_done       in   one-cycle pulse: frame at render_ptr is complete
//   render_ptr        out  base address of the current back buffer
//   render_ready      out  renderer may draw into render_ptr
//   frame_buffer_ptr  out  display base address for the VGA unit
//   flip_pending      out  a completed frame is waiting for vblank
//   frame_count       out  flips performed (wraps)
//   drop_count        out  pending frames overwritten before display
//                          (saturates at 255)
// -----------------------------------------------------------------------------
module fb_flip_ctrl #(
    parameter logic [31:0] FB_BASE = 32'h0000_0000,
    parameter logic [31:0] FB_SIZE = 32'h0004_B000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic        render_done,
    output logic [31:0] render_ptr,
    output logic        render_ready,
    output logic [31:0] frame_buffer_ptr,
    output logic        flip_pending,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

    function automatic logic [31:0] buf_base(input logic [1:0] idx);
        return FB_BASE + FB_SIZE * {30'd0, idx};
    endfunction

    // -------------------------------------------------------------------------
    // Vblank detection.
    // Two synchronizer flops, then a delay flop. All three reset high, so a
    // reset can never fabricate a falling edge. The detected edge is
    // registered once more. That places the buffer swap, which is computed
    // from vb_edge_reg, on edge n+3 of a fall first sampled at edge n.
    // -------------------------------------------------------------------------
    logic vs_sync1_reg;
    logic vs_sync2_reg;
    logic vs_prev_reg;
    logic vb_edge_reg;
    logic vb_edge;

    assign vb_edge = vs_prev_reg & ~vs_sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_sync1_reg <= 1'b1;
            vs_sync2_reg <= 1'b1;
            vs_prev_reg  <= 1'b1;
            vb_edge_reg  <= 1'b0;
        end else begin
            vs_sync1_reg <= vga_vs;
            vs_sync2_reg <= vs_sync1_reg;
            vs_prev_reg  <= vs_sync2_reg;
            vb_edge_reg  <= vb_edge;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer bookkeeping. Each mode produces the same set of *_next values.
    // The registered outputs are then loaded from them.
    // -------------------------------------------------------------------------
    logic [1:0]  front_reg;
    logic [1:0]  back_reg;
    logic [1:0]  front_next;
    logic [1:0]  back_next;
    logic        pend_v_next;
    logic        ready_next;
    logic [15:0] frame_count_next;
    logic [7:0]  drop_count_next;

`ifdef FB_FLIP_TRIPLE_BUFFER_EN

    // Mailbox: the renderer never waits. A newer frame replaces an
    // undisplayed pending frame, and that replacement counts as a drop.
    logic [1:0] pend_reg;
    logic [1:0] pend_next;
    logic       pend_v_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            front_reg  <= 2'd0;
            back_reg   <= 2'd1;
            pend_reg   <= 2'd2;
            pend_v_reg <= 1'b0;
        end else begin
            front_reg  <= front_next;
            back_reg   <= back_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
        end
    end

    always_comb begin
        front_next       = front_reg;
        back_next        = back_reg;
        pend_next        = pend_reg;
        pend_v_next      = pend_v_reg;
        frame_count_next = frame_count;
        drop_count_next  = drop_count;
        ready_next       = 1'b1;

        // Vblank is resolved first. In a coincident cycle, render_done then
        // queues against the post-flip state, and the old front becomes the
        // new back.
        if (vb_edge_reg && pend_v_reg) begin
            front_next       = pend_reg;
            pend_v_next      = 1'b0;
            frame_count_next = frame_count + 16'd1;
        end

        if (render_done) begin
            // One idle cycle lets the renderer see the new render_ptr.
            ready_next = 1'b0;
            if (pend_v_next) begin
                pend_next = back_reg;
                back_next = pend_reg;
                if (drop_count != 8'hFF) begin
                    drop_count_next = drop_count + 8'd1;
                end
            end else begin
                pend_next   = back_reg;
                // Indices 0..2 sum to 3, so this yields the unused buffer.
                back_next   = 2'd3 - front_next - back_reg;
                pend_v_next = 1'b1;
            end
        end
    end

`else

    // Double buffering: the renderer stalls from render_done until vblank.
    // The pending frame is always the back buffer, so the state alone marks
    // it as valid.
    typedef enum logic {
        RENDER    = 1'b0,
        WAIT_FLIP = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RENDER;
            front_reg <= 2'd0;
            back_reg  <= 2'd1;
        end else begin
            state_reg <= state_next;
            front_reg <= front_next;
            back_reg  <= back_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        front_next       = front_reg;
        back_next        = back_reg;
        frame_count_next = frame_count;
        drop_count_next  = 8'd0;

        case (state_reg)
            // A vblank seen in this state is not retroactive for a frame
            // that completes in the same cycle.
            RENDER: begin
                if (render_done) begin
                    state_next = WAIT_FLIP;
                end
            end
            // Further render_done pulses are ignored while the flip waits.
            WAIT_FLIP: begin
                if (vb_edge_reg) begin
                    front_next       = back_reg;
                    back_next        = front_reg;
                    frame_count_next = frame_count + 16'd1;
                    state_next       = RENDER;
                end
            end
            default: begin
                state_next = RENDER;
            end
        endcase

        pend_v_next = (state_next == WAIT_FLIP);
        ready_next  = (state_next == RENDER);
    end

`endif

    // -------------------------------------------------------------------------
    // Registered outputs, loaded from next-state values. A render_done at
    // edge k is therefore visible at edge k+1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_buffer_ptr <= FB_BASE;
            render_ptr       <= FB_BASE + FB_SIZE;
            render_ready     <= 1'b0;
            flip_pending     <= 1'b0;
            frame_count      <= 16'd0;
            drop_count       <= 8'd0;
        end else begin
            frame_buffer_ptr <= buf_base(front_next);
            render_ptr       <= buf_base(back_next);
            render_ready     <= ready_next;
            flip_pending     <= pend_v_next;
            frame_count      <= frame_count_next;
            drop_count       <= drop_count_next;
        end
    end

endmodule
